// File: rtl/pipa_cnt_sched.sv
// PIPA counter-increment scheduler: captures accelerometer pulses, cancels opposing
// pairs and issues one 12-pulse PINC/MINC cycle per axis, evaluated once per TP=12.
module pipa_cnt_sched (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       PIPAXp,
  input  logic       PIPAXm,
  input  logic       PIPAYp,
  input  logic       PIPAYm,
  input  logic       PIPAZp,
  input  logic       PIPAZm,
  input  logic       GOJAM,
  input  logic       CTINH,
  input  logic       FLCLR,
  output logic [3:0] TP,
  output logic       PINC,
  output logic       MINC,
  output logic [1:0] CTADR,
  output logic       CTBUSY,
  output logic       PIPAFL
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  logic [3:0] tp_q, tp_d;
  logic [5:0] prev_q;
  logic [5:0] pend_q, pend_d;
  logic       pinc_q, pinc_d;
  logic       minc_q, minc_d;
  logic [1:0] ctadr_q, ctadr_d;
  logic       pipafl_q, pipafl_d;

  logic [5:0] pipa;
  logic [5:0] rise;
  logic [5:0] clr;
  logic [5:0] avail;
  logic [5:0] lost;
  logic       found;
  logic       eval;

  // Bit pairs per axis: [1:0]=X, [3:2]=Y, [5:4]=Z; even bit is the plus line.
  assign pipa = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};
  assign rise = pipa & ~prev_q;
  assign eval = (tp_q == 4'd12);
  assign tp_d = eval ? 4'd1 : tp_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    pinc_d   = pinc_q;
    minc_d   = minc_q;
    ctadr_d  = ctadr_q;
    clr      = '0;
    avail    = '0;
    found    = 1'b0;
    lost     = '0;
    pend_d   = pend_q;
    pipafl_d = pipafl_q;

    if (eval) begin
      for (int a = 0; a < 3; a++) begin
        if (pend_q[2*a] && pend_q[2*a+1]) clr[2*a +: 2] = 2'b11;
      end
      avail   = pend_q & ~clr;
      state_d = StIdle;
      pinc_d  = 1'b0;
      minc_d  = 1'b0;
      ctadr_d = 2'd3;
      if (!CTINH && !GOJAM) begin
        for (int a = 0; a < 3; a++) begin
          if (!found && (avail[2*a +: 2] != 2'b00)) begin
            found           = 1'b1;
            clr[2*a +: 2]   = clr[2*a +: 2] | avail[2*a +: 2];
            ctadr_d         = 2'(a);
            pinc_d          = avail[2*a];
            minc_d          = avail[2*a+1];
            state_d         = StRun;
          end
        end
      end
    end

    // An edge arriving while its bit is being consumed re-arms it without loss.
    lost   = rise & pend_q & ~clr;
    pend_d = (pend_q & ~clr) | rise;
    if (lost != 6'b0) begin
      pipafl_d = 1'b1;
    end else if (FLCLR) begin
      pipafl_d = 1'b0;
    end

    if (GOJAM) begin
      pend_d   = '0;
      state_d  = StIdle;
      pinc_d   = 1'b0;
      minc_d   = 1'b0;
      ctadr_d  = 2'd3;
      pipafl_d = FLCLR ? 1'b0 : pipafl_q;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q  <= StIdle;
      tp_q     <= 4'd1;
      prev_q   <= '0;
      pend_q   <= '0;
      pinc_q   <= 1'b0;
      minc_q   <= 1'b0;
      ctadr_q  <= 2'd3;
      pipafl_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tp_q     <= tp_d;
      prev_q   <= pipa;
      pend_q   <= pend_d;
      pinc_q   <= pinc_d;
      minc_q   <= minc_d;
      ctadr_q  <= ctadr_d;
      pipafl_q <= pipafl_d;
    end
  end

  assign TP     = tp_q;
  assign PINC   = pinc_q;
  assign MINC   = minc_q;
  assign CTADR  = ctadr_q;
  assign CTBUSY = (state_q == StRun);
  assign PIPAFL = pipafl_q;

endmodule

// File: doc/pipa_cnt_sched.md
PIPA_CNT_SCHED -- requirements
Module: pipa_cnt_sched

Interface
REQ-001 SHALL have port CLOCK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm, input, 1 bit each: accelerometer pulse lines; a rising edge is one count.
REQ-004 SHALL have port GOJAM, input, 1 bit: restart; aborts sequencing synchronously.
REQ-005 SHALL have port CTINH, input, 1 bit: datapath inhibit; blocks new cycle selection only.
REQ-006 SHALL have port FLCLR, input, 1 bit: clears the lost-pulse flag.
REQ-007 SHALL have port TP, output, 4 bits: time-pulse number, range 1..12.
REQ-008 SHALL have ports PINC and MINC, output, 1 bit each: plus/minus counter-increment request to the arithmetic datapath.
REQ-009 SHALL have port CTADR, output, 2 bits: axis served (0=X, 1=Y, 2=Z, 3=none).
REQ-010 SHALL have port CTBUSY, output, 1 bit: an increment cycle is in progress.
REQ-011 SHALL have port PIPAFL, output, 1 bit: sticky lost-pulse flag.

Function
REQ-012 TP SHALL increment by 1 every CLOCK and wrap from 12 to 1; GOJAM SHALL NOT affect TP.
REQ-013 Each PIPA input SHALL be registered once (prev, reset 0); rising edge = input 1 and prev 0.
REQ-014 A rising edge SHALL set that line's pending bit pend[5:0] (order Xp, Xm, Yp, Ym, Zp, Zm).
REQ-015 A rising edge on a line whose pending bit is already set and not being cleared that clock SHALL set PIPAFL; pending stays 1 (one count lost).
REQ-016 If a pending bit is cleared by selection on the same clock as a new edge on that line, the bit SHALL end at 1 and PIPAFL SHALL NOT set.
REQ-017 FSM SHALL have two states, IDLE and RUN; evaluation SHALL occur only on clocks where TP==12.
REQ-018 At evaluation, per axis with both + and - pending, both bits SHALL clear (net zero), no cycle issued for that axis.
REQ-019 After cancellation, the lowest-index axis (X>Y>Z) with exactly one pending bit SHALL be selected; that bit cleared; CTADR loaded with the axis; PINC (plus) or MINC (minus) set; state RUN.
REQ-020 Selection SHALL be suppressed when CTINH=1 or GOJAM=1 at evaluation; cancellation SHALL still occur when CTINH=1.
REQ-021 In RUN, PINC/MINC, CTADR and CTBUSY SHALL hold for exactly 12 clocks (TP 1..12 following selection).
REQ-022 At TP==12 in RUN, a new evaluation SHALL occur; if selectable, RUN SHALL continue back-to-back with new CTADR/sign, else go IDLE with PINC=MINC=0, CTADR=3, CTBUSY=0.
REQ-023 PINC and MINC SHALL never both be 1.
REQ-024 GOJAM=1 SHALL clear pend, force IDLE, and drive PINC=MINC=CTBUSY=0, CTADR=3 on the next clock; edges during GOJAM SHALL be discarded; PIPAFL unchanged.
REQ-025 FLCLR SHALL clear PIPAFL next clock; a simultaneous set condition SHALL win.

Reset
REQ-026 rst SHALL set TP=1, pend=0, prev=0, state IDLE, PINC=MINC=0, CTADR=3, CTBUSY=0, PIPAFL=0 on the next clock, overriding all other inputs including mid-cycle RUN.

Verification
REQ-027 Single PIPAYp edge at TP=5 -> at next TP=12 selection; PINC=1, CTADR=1, CTBUSY=1 for exactly 12 clocks, then idle (CTADR=3).
REQ-028 PIPAXm and PIPAZp edges same clock -> X served first (MINC, CTADR=0, 12 clocks), then back-to-back Z (PINC, CTADR=2, 12 clocks), no gap.
REQ-029 PIPAZp and PIPAZm both pending at evaluation -> both cleared, PINC=MINC=0, CTADR stays 3.
REQ-030 Two PIPAXp edges before an evaluation -> PIPAFL=1 after second edge, one PINC cycle issued; FLCLR pulse -> PIPAFL=0.
REQ-031 CTINH=1 across two evaluations with PIPAYm pending -> no cycle; CTINH=0 -> MINC, CTADR=1 at next TP=12.
REQ-032 GOJAM mid-RUN (TP=6) with Z pending -> next clock PINC=MINC=0, CTADR=3, pend=0; TP continues 7,8,...
